signal_receiver: RTL and testbench

//  Serial-to-parallel receiver and frame checker for the serial stream out of
//  the signal creater (parallel D loaded, shifted out one bit per clk, D[0] first).

---
 rtl/signal_receiver.sv | 130 +++++++++++++
 tb/tb_signal_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/signal_receiver.sv
// signal_receiver: rebuilds W-bit frames from a serial stream, slides bit-by-bit to find alignment
// against D, then checks every following frame. Optional err_cnt port when SIGNAL_RX_ERR_EN is defined.
module signal_receiver #(
    parameter int W        = 4,
    parameter int CNT_W    = 8,
    parameter int MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic [0:W-1]     D,
    output logic [0:W-1]     out_word,
    output logic             match,
    output logic             locked,
    output logic [CNT_W-1:0] match_cnt
`ifdef SIGNAL_RX_ERR_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int FILL_W = $clog2(W + 1);
    localparam int PH_W   = $clog2(W);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state, state_d;
    logic [FILL_W-1:0] fill, fill_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic [MISS_W-1:0] miss, miss_d;
    logic [0:W-1]      window;
    logic              frame_full;
    logic              hit;
    logic              match_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Window includes the bit being taken on this edge, so compares see the completed frame.
    assign window     = {out_word[1:W-1], in};
    assign frame_full = (fill >= FILL_W'(W - 1));
    assign hit        = (window == D);
    assign locked     = (state == LOCKED);
    assign fill_d     = (fill == FILL_W'(W)) ? fill : fill + FILL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        miss_d  = miss;
        match_d = 1'b0;
        if (en) begin
            case (state)
                SEARCH: begin
                    if (frame_full && hit) begin
                        state_d = LOCKED;
                        phase_d = '0;
                        miss_d  = '0;
                        match_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (phase == PH_W'(W - 1)) begin
                        phase_d = '0;
                        if (hit) begin
                            match_d = 1'b1;
                            miss_d  = '0;
                        end else if (miss == MISS_W'(MISS_MAX - 1)) begin
                            // Losing lock: search resumes on the next bit with fill kept full.
                            state_d = SEARCH;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss + MISS_W'(1);
                        end
                    end else begin
                        phase_d = phase + PH_W'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_word  <= '0;
            fill      <= '0;
            phase     <= '0;
            miss      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= match_d;
            if (en) begin
                out_word <= window;
                fill     <= fill_d;
                phase    <= phase_d;
                miss     <= miss_d;
            end
            if (match_d) begin
                match_cnt <= sat_inc(match_cnt);
            end
        end
    end

`ifdef SIGNAL_RX_ERR_EN
    logic frame_err;

    assign frame_err = en && (state == LOCKED) && (phase == PH_W'(W - 1)) && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (frame_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_signal_receiver.sv
// Directed table-driven bench for signal_receiver (W=4, MISS_MAX=2) plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation. Define SIGNAL_RX_ERR_EN to also check err_cnt.
module tb_signal_receiver;
    logic       clk = 1'b0;
    logic       rst, en, din;
    logic [0:3] d;
    logic [0:3] out_word, out_word2;
    logic       match, locked, match2, locked2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
`ifdef SIGNAL_RX_ERR_EN
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       en;
        logic       din;
        logic [0:3] d;
        logic       m;
        logic       l;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    signal_receiver #(.W(4), .CNT_W(8), .MISS_MAX(2)) dut (
        .clk(clk), .rst(rst), .en(en), .in(din), .D(d),
        .out_word(out_word), .match(match), .locked(locked), .match_cnt(match_cnt)
`ifdef SIGNAL_RX_ERR_EN
        , .err_cnt(err_cnt)
`endif
    );

    signal_receiver #(.W(4), .CNT_W(2), .MISS_MAX(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in(din), .D(d),
        .out_word(out_word2), .match(match2), .locked(locked2), .match_cnt(match_cnt2)
`ifdef SIGNAL_RX_ERR_EN
        , .err_cnt(err_cnt2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic e, input logic b, input logic [0:3] dd,
                        input logic m, input logic l);
        vec_t v;
        v.en  = e;
        v.din = b;
        v.d   = dd;
        v.m   = m;
        v.l   = l;
        vecs.push_back(v);
    endtask

    task automatic addframe(input logic [0:3] bits, input logic [0:3] dd,
                            input logic m_last, input logic l_before, input logic l_last);
        for (int i = 0; i < 3; i++) addv(1'b1, bits[i], dd, 1'b0, l_before);
        addv(1'b1, bits[3], dd, m_last, l_last);
    endtask

    // Each record: drive on the falling edge, compare {match,locked} just after the rising edge.
    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            en  = vecs[i].en;
            din = vecs[i].din;
            d   = vecs[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] {match,locked}", tag, i),
                {30'd0, match, locked}, {30'd0, vecs[i].m, vecs[i].l});
        end
        vecs.delete();
        en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:3] good, bad, zero, ones;
        good = 4'b1001;
        bad  = 4'b1101;
        zero = 4'b0000;
        ones = 4'b1111;

        rst = 1'b1;
        en  = 1'b0;
        din = 1'b0;
        d   = good;
        repeat (2) @(negedge clk);
        chk("reset locked", {31'd0, locked}, 32'd0);
        chk("reset match", {31'd0, match}, 32'd0);
        chk("reset out_word", {28'd0, out_word}, 32'd0);
        chk("reset match_cnt", {24'd0, match_cnt}, 32'd0);
        rst = 1'b0;

        // Initial lock, then eight more aligned frames.
        addframe(good, good, 1'b1, 1'b0, 1'b1);
        run_vecs("lock");
        chk("lock match_cnt", {24'd0, match_cnt}, 32'd1);
        for (int f = 0; f < 8; f++) addframe(good, good, 1'b1, 1'b1, 1'b1);
        run_vecs("run");
        chk("run match_cnt", {24'd0, match_cnt}, 32'd9);
        chk("run out_word", {28'd0, out_word}, 32'h9);
        chk("sat match_cnt2", {30'd0, match_cnt2}, 32'd3);

        // One corrupt frame keeps lock.
        addframe(bad, good, 1'b0, 1'b1, 1'b1);
        addframe(good, good, 1'b1, 1'b1, 1'b1);
        run_vecs("onebad");
        chk("onebad match_cnt", {24'd0, match_cnt}, 32'd10);
`ifdef SIGNAL_RX_ERR_EN
        chk("onebad err_cnt", {24'd0, err_cnt}, 32'd1);
`endif

        // Two corrupt frames drop lock; two stray bits then a realigned stream relocks.
        addframe(bad, good, 1'b0, 1'b1, 1'b1);
        addframe(bad, good, 1'b0, 1'b1, 1'b0);
        addv(1'b1, 1'b0, good, 1'b0, 1'b0);
        addv(1'b1, 1'b1, good, 1'b0, 1'b0);
        addframe(good, good, 1'b1, 1'b0, 1'b1);
        addframe(good, good, 1'b1, 1'b1, 1'b1);
        run_vecs("drop");
        chk("drop match_cnt", {24'd0, match_cnt}, 32'd12);
`ifdef SIGNAL_RX_ERR_EN
        chk("drop err_cnt", {24'd0, err_cnt}, 32'd3);
`endif

        // Nine frames with 1..3 idle cycles after every bit; idle input carries junk.
        for (int f = 0; f < 9; f++) begin
            for (int b = 0; b < 4; b++) begin
                addv(1'b1, good[b], good, (b == 3), 1'b1);
                for (int g = 0; g < ((f * 4 + b) % 3) + 1; g++)
                    addv(1'b0, ~good[b], good, 1'b0, 1'b1);
            end
        end
        run_vecs("gaps");
        chk("gaps match_cnt", {24'd0, match_cnt}, 32'd21);
        chk("gaps out_word", {28'd0, out_word}, 32'h9);
`ifdef SIGNAL_RX_ERR_EN
        chk("gaps err_cnt", {24'd0, err_cnt}, 32'd3);
`endif

        // Asynchronous reset in the middle of a locked frame.
        addv(1'b1, 1'b1, good, 1'b0, 1'b1);
        addv(1'b1, 1'b0, good, 1'b0, 1'b1);
        run_vecs("midframe");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async rst locked", {31'd0, locked}, 32'd0);
        chk("async rst out_word", {28'd0, out_word}, 32'd0);
        chk("async rst match_cnt", {24'd0, match_cnt}, 32'd0);
        chk("async rst match_cnt2", {30'd0, match_cnt2}, 32'd0);
`ifdef SIGNAL_RX_ERR_EN
        chk("async rst err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // All-zero pattern: an unfilled window of reset zeros must not match early.
        addframe(zero, zero, 1'b1, 1'b0, 1'b1);
        // D switches exactly on the compare edge of a 1111 frame.
        for (int i = 0; i < 3; i++) addv(1'b1, 1'b1, zero, 1'b0, 1'b1);
        addv(1'b1, 1'b1, ones, 1'b1, 1'b1);
        run_vecs("fresh");
        chk("fresh match_cnt", {24'd0, match_cnt}, 32'd2);

        // Fresh run of five frames: 8-bit counter reaches 5, 2-bit counter holds at 3.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        addframe(good, good, 1'b1, 1'b0, 1'b1);
        for (int f = 0; f < 4; f++) addframe(good, good, 1'b1, 1'b1, 1'b1);
        run_vecs("five");
        chk("five match_cnt", {24'd0, match_cnt}, 32'd5);
        chk("five match_cnt2", {30'd0, match_cnt2}, 32'd3);
        chk("five locked2", {31'd0, locked2}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
